secded_mem_engine: RTL and testbench
====================================

// Module: secded_mem_engine
// PURPOSE
//  Hardware SECDED Hamming engine; replaces software encode/decode loops. On start, walks COUNT
//  codewords in the byte-wide data memory, encodes, decodes/corrects, or check-only scans them.
//  Decode writes corrected data to a destination region and counts single/double errors.
//  Sits beside the core on the data-memory port; start/done handshake as TopLevel.
// PARAMETERS
//  DATA_W  11  data bits per word; legal 4/11/26/57 -> CODE_W 8/16/32/64, NB=CODE_W/8 bytes
//  ADDR_W   8  data-memory byte address width
//  CNT_W    8  width of count and status counters
// PORTS
//  CLK          in   1       clock, all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       begin job; sampled only in IDLE/DONE
//  mode         in   2       0 encode, 1 decode+correct, 2/3 check-only (no writes)
//  src_base     in   ADDR_W  first source byte address
//  dst_base     in   ADDR_W  first destination byte address
//  count        in   CNT_W   number of words (0 legal)
//  mem_addr     out  ADDR_W  memory byte address
//  mem_rd_data  in   8       read data, valid 1 cycle after mem_addr (synchronous read)
//  mem_wr_en    out  1       byte write strobe
//  mem_wr_data  out  8       byte to write
//  busy         out  1       high from start accept until done rises
//  done         out  1       level; high after job end until next start accepted
//  corr_cnt     out  CNT_W   single errors corrected this job (saturates at all-ones)
//  dbl_cnt      out  CNT_W   double errors detected this job (saturates)
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (mem_addr, mem_wr_en, busy, done, counters).
//  Codeword layout: bit i (1..CODE_W-1) = Hamming position i; power-of-2 positions are parity,
//   data d1..dDATA_W fill remaining positions ascending; bit 0 = XOR of bits 1..CODE_W-1.
//   Default: {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}. Bytes little-endian, word w at base+w*NB.
//  Encode: in = data zero-extended in NB bytes (bits above DATA_W ignored); out = codeword.
//  Decode: s = syndrome (XOR of positions with set bits), q = overall parity of all CODE_W bits.
//   s=0,q=0: clean. q=1: single error at position s (s=0 -> bit 0); flip it, corr_cnt++.
//   s!=0,q=0: double error; out bit CODE_W-1 = 1, data field = uncorrected extracted data, dbl_cnt++.
//   Output: data in bits DATA_W-1:0, zeros above except double-error flag.
//  Check-only: decode counters updated, mem_wr_en never asserted.
//  FSM: IDLE -> READ (NB+1 cyc: cycle k<NB drives addr src+w*NB+k, cycle k>=1 captures byte k-1)
//   -> CALC (1 cyc) -> WRITE (NB cyc, byte k to dst+w*NB+k; skipped in check-only)
//   -> READ next word or DONE after word count-1. DONE --start--> READ (or DONE if count=0).
//  Latency: count*(2*NB+2) cycles encode/decode, count*(NB+2) check-only, start-accept to done.
//  count=0: done rises cycle after accept, no memory access.
//  Start accept: clears counters and done, latches mode/src_base/dst_base/count; busy=1.
//  start while busy: ignored; inputs may change freely during job.
//  Address arithmetic wraps modulo 2^ADDR_W; overlapping src/dst legal (each word read before write).
//  Reset mid-job: immediate abort to IDLE, mem_wr_en=0 same instant, partial results stay in memory.
// TESTING
//  T1 encode, count=3, data 0x000,0x7FF,0x001 -> codewords 0x0000,0xFFFF,0x000F; done after 18 cyc.
//  T2 decode 0x020F (pos9 flipped) -> 0x0001, corr_cnt=1; 0x000E (bit0 flipped) -> 0x0001, corr_cnt=2.
//  T3 decode 0x021F (pos9+pos4) -> 0x8011, dbl_cnt=1, corr_cnt=0.
//  T4 15 random words, 1-2 random flips (program-2 style) vs model; check-only pass -> no writes,
//     same counters; count=0 -> done in 1 cycle.
//  T5 DATA_W=26: encode 26'h1 -> 32'h0000000F; decode with bit 31 flipped -> 32'h00000001.
//  T6 reset_n low mid-WRITE -> mem_wr_en/busy/done/counters 0 at once; restart completes normally.

Source files
------------

// File: rtl/secded_mem_engine_if.sv
// Purpose: control/status and data-memory port bundle between a core and secded_mem_engine.
// Latency: n/a (wires only); memory read data is expected one cycle after mem_addr.
// Backpressure: none; the memory is always ready and start is ignored while the engine is busy.
// Ports: start/mode/src_base/dst_base/count (job request), busy/done/corr_cnt/dbl_cnt (status),
//        mem_addr/mem_wr_en/mem_wr_data/mem_rd_data (byte-wide synchronous data memory).
interface secded_mem_engine_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  dbl_cnt;

    modport slave (
        input  start, mode, src_base, dst_base, count, mem_rd_data,
        output mem_addr, mem_wr_en, mem_wr_data, busy, done, corr_cnt, dbl_cnt
    );

    modport master (
        output start, mode, src_base, dst_base, count, mem_rd_data,
        input  mem_addr, mem_wr_en, mem_wr_data, busy, done, corr_cnt, dbl_cnt
    );
endinterface

// File: rtl/secded_mem_engine.sv
// Purpose: walks COUNT SECDED Hamming codewords in byte memory: encode, decode+correct, or check-only.
// Latency: count*(2*NB+2) cycles start-accept to done (check-only count*(NB+2)); count=0 -> 1 cycle.
// Backpressure: none; memory must answer every read next cycle, start is ignored while busy.
// Ports: CLK, reset_n (async, active-low), bus (slave side of secded_mem_engine_if).
module secded_mem_engine #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               CLK,
    input  logic               reset_n,
    secded_mem_engine_if.slave bus
);
    localparam int CODE_W = (DATA_W <= 4) ? 8 : (DATA_W <= 11) ? 16 : (DATA_W <= 26) ? 32 : 64;
    localparam int NB     = CODE_W / 8;
    localparam int LOG_C  = $clog2(CODE_W);
    localparam int K_W    = 4;
    localparam logic [K_W-1:0] NB_K = K_W'(NB);

    // S_ZERO gives a count=0 job its one cycle of done=0 before done rises.
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_ZERO, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CODE_W-1:0] rbuf_q, rbuf_d, wbuf_q, wbuf_d;
    logic [CNT_W-1:0]  corr_q, corr_d, dbl_q, dbl_d;

    // Data bits occupy the non-power-of-two positions 1..CODE_W-1 in ascending order.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int b = 0; b < LOG_C; b++) begin
            for (int i = 1; i < CODE_W; i++) begin
                if (((i >> b) & 1) == 1 && i != (1 << b)) c[1 << b] = c[1 << b] ^ c[i];
            end
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                r[j] = c[i];
                j++;
            end
        end
        return r;
    endfunction

    logic [LOG_C-1:0]  syn;
    logic              par;
    logic              is_dbl;
    logic [CODE_W-1:0] fixed;
    logic [CODE_W-1:0] dec_word;

    // Decode path: syndrome and overall parity of the captured word. On a double
    // error par=0 so nothing is flipped and the raw data field is reported.
    always_comb begin
        syn = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (rbuf_q[i]) syn = syn ^ LOG_C'(i);
        end
        par    = ^rbuf_q;
        is_dbl = ~par && (syn != '0);
        fixed  = rbuf_q;
        if (par) fixed[syn] = ~fixed[syn];
        dec_word               = '0;
        dec_word[DATA_W-1:0]   = extract(fixed);
        dec_word[CODE_W-1]     = is_dbl;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        left_d  = left_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rbuf_d  = rbuf_q;
        wbuf_d  = wbuf_q;
        corr_d  = corr_q;
        dbl_d   = dbl_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    corr_d  = '0;
                    dbl_d   = '0;
                    mode_d  = bus.mode;
                    src_d   = bus.src_base;
                    dst_d   = bus.dst_base;
                    left_d  = bus.count;
                    k_d     = '0;
                    state_d = (bus.count == '0) ? S_ZERO : S_READ;
                end
            end
            S_ZERO: state_d = S_DONE;
            S_READ: begin
                // Byte k-1 arrives the cycle after its address was driven.
                if (k_q != '0) rbuf_d[{k_q - K_W'(1), 3'b000} +: 8] = bus.mem_rd_data;
                if (k_q == NB_K) begin
                    k_d     = '0;
                    state_d = S_CALC;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_CALC: begin
                wbuf_d = (mode_q == 2'd0) ? encode(rbuf_q[DATA_W-1:0]) : dec_word;
                if (mode_q != 2'd0) begin
                    if (par && corr_q != '1) corr_d = corr_q + CNT_W'(1);
                    if (is_dbl && dbl_q != '1) dbl_d = dbl_q + CNT_W'(1);
                end
                if (mode_q[1]) begin
                    src_d   = src_q + ADDR_W'(NB);
                    dst_d   = dst_q + ADDR_W'(NB);
                    left_d  = left_q - CNT_W'(1);
                    state_d = (left_q == CNT_W'(1)) ? S_DONE : S_READ;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (k_q == NB_K - K_W'(1)) begin
                    k_d     = '0;
                    src_d   = src_q + ADDR_W'(NB);
                    dst_d   = dst_q + ADDR_W'(NB);
                    left_d  = left_q - CNT_W'(1);
                    state_d = (left_q == CNT_W'(1)) ? S_DONE : S_READ;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            left_q  <= '0;
            mode_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rbuf_q  <= '0;
            wbuf_q  <= '0;
            corr_q  <= '0;
            dbl_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            left_q  <= left_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rbuf_q  <= rbuf_d;
            wbuf_q  <= wbuf_d;
            corr_q  <= corr_d;
            dbl_q   <= dbl_d;
        end
    end

    // Memory outputs decode straight from state so a reset drops mem_wr_en at once.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        if (state_q == S_READ && k_q < NB_K) begin
            bus.mem_addr = src_q + ADDR_W'(k_q);
        end else if (state_q == S_WRITE) begin
            bus.mem_addr    = dst_q + ADDR_W'(k_q);
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = wbuf_q[{k_q, 3'b000} +: 8];
        end
    end

    assign bus.busy     = (state_q == S_READ) || (state_q == S_CALC) ||
                          (state_q == S_WRITE) || (state_q == S_ZERO);
    assign bus.done     = (state_q == S_DONE);
    assign bus.corr_cnt = corr_q;
    assign bus.dbl_cnt  = dbl_q;
endmodule

// File: tb/tb_secded_mem_engine.sv
// Purpose: scoreboard bench for secded_mem_engine (DATA_W=11 and DATA_W=26 instances).
// Latency: checks start-accept to done cycle counts per job.
// Backpressure: memory model answers every read one cycle later.
module tb_secded_mem_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    secded_mem_engine_if #(.ADDR_W(8), .CNT_W(8)) bus_a ();
    secded_mem_engine_if #(.ADDR_W(8), .CNT_W(8)) bus_b ();

    secded_mem_engine #(.DATA_W(11), .ADDR_W(8), .CNT_W(8)) u_dut (
        .CLK(clk), .reset_n(rst_n), .bus(bus_a));
    secded_mem_engine #(.DATA_W(26), .ADDR_W(8), .CNT_W(8)) u_dut26 (
        .CLK(clk), .reset_n(rst_n), .bus(bus_b));

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       bd_we = 1'b0;
    logic       bd_sel = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;

    always @(posedge clk) begin
        if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_wr_data;
        else if (bd_we && !bd_sel) mem_a[bd_addr] <= bd_data;
        bus_a.mem_rd_data <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_wr_data;
        else if (bd_we && bd_sel) mem_b[bd_addr] <= bd_data;
        bus_b.mem_rd_data <= mem_b[bus_b.mem_addr];
    end

    typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [7:0] corr; logic [7:0] dbl;} job_t;
    wr_t  exp_wr_a[$];
    wr_t  exp_wr_b[$];
    job_t exp_job_a[$];
    job_t exp_job_b[$];
    bit   mon_ignore = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (Hamming rules, position arithmetic) ----------------
    function automatic logic [63:0] m_encode(input int cw, input logic [63:0] d);
        logic [63:0] c;
        int j, s;
        c = '0; j = 0; s = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1) begin
                if (d[j]) begin c[pos] = 1'b1; s = s ^ pos; end
                j++;
            end
        end
        // Setting parity bit p cancels bit p of the data syndrome, giving syndrome 0.
        for (int p = 1; p < cw; p = p * 2) if ((s & p) != 0) c[p] = 1'b1;
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [63:0] m_extract(input int cw, input logic [63:0] c);
        logic [63:0] r;
        int j;
        r = '0; j = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1) begin r[j] = c[pos]; j++; end
        end
        return r;
    endfunction

    function automatic logic [63:0] m_decode(input int cw, input logic [63:0] c);
        int s;
        logic q;
        logic [63:0] r;
        s = 0;
        for (int pos = 1; pos < cw; pos++) if (c[pos]) s = s ^ pos;
        q = ^c;
        if (q) c[s] = ~c[s];
        r = m_extract(cw, c);
        if (!q && s != 0) r[cw-1] = 1'b1;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic put_word(input bit sel, input logic [7:0] addr, input logic [63:0] w, input int nb);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_sel = sel; bd_addr = addr + 8'(k); bd_data = w[8*k +: 8];
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic expect_word(input bit sel, input logic [7:0] addr, input logic [63:0] w, input int nb);
        wr_t e;
        for (int k = 0; k < nb; k++) begin
            e.addr = addr + 8'(k);
            e.data = w[8*k +: 8];
            if (sel) exp_wr_b.push_back(e); else exp_wr_a.push_back(e);
        end
    endtask

    task automatic expect_job(input bit sel, input logic [7:0] corr, input logic [7:0] dbl);
        job_t j;
        j.corr = corr; j.dbl = dbl;
        if (sel) exp_job_b.push_back(j); else exp_job_a.push_back(j);
    endtask

    task automatic run_job(input bit sel, input logic [1:0] mode, input logic [7:0] src,
                           input logic [7:0] dst, input logic [7:0] cnt, input int exp_lat);
        int   cyc;
        logic d;
        @(negedge clk);
        if (sel) begin
            bus_b.start = 1'b1; bus_b.mode = mode; bus_b.src_base = src; bus_b.dst_base = dst; bus_b.count = cnt;
        end else begin
            bus_a.start = 1'b1; bus_a.mode = mode; bus_a.src_base = src; bus_a.dst_base = dst; bus_a.count = cnt;
        end
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        // Job parameters are latched at accept; scramble the live inputs.
        bus_a.mode = 2'($urandom); bus_a.src_base = 8'($urandom); bus_a.dst_base = 8'($urandom); bus_a.count = 8'($urandom);
        bus_b.mode = 2'($urandom); bus_b.src_base = 8'($urandom); bus_b.dst_base = 8'($urandom); bus_b.count = 8'($urandom);
        cyc = 0;
        d = sel ? bus_b.done : bus_a.done;
        while (!d && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            d = sel ? bus_b.done : bus_a.done;
        end
        chk("job_latency", 64'(cyc), 64'(exp_lat));
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_step(input bit sel, input logic wr_en, input logic [7:0] addr, input logic [7:0] data,
                            input logic done_rise, input logic [7:0] corr, input logic [7:0] dbl);
        wr_t  e;
        job_t j;
        int   n;
        if (wr_en && !(mon_ignore && !sel)) begin
            n = sel ? exp_wr_b.size() : exp_wr_a.size();
            if (n == 0) begin
                vectors++;
                errors++;
                $display("FAIL mem_write[%0d]: got write 0x%02h at 0x%02h, expected no write", sel, data, addr);
            end else begin
                if (sel) e = exp_wr_b.pop_front(); else e = exp_wr_a.pop_front();
                chk("mem_wr_addr", 64'(addr), 64'(e.addr));
                chk("mem_wr_data", 64'(data), 64'(e.data));
            end
        end
        if (done_rise) begin
            n = sel ? exp_job_b.size() : exp_job_a.size();
            if (n == 0) begin
                vectors++;
                errors++;
                $display("FAIL done[%0d]: got done rise, expected none", sel);
            end else begin
                if (sel) j = exp_job_b.pop_front(); else j = exp_job_a.pop_front();
                chk("corr_cnt", 64'(corr), 64'(j.corr));
                chk("dbl_cnt", 64'(dbl), 64'(j.dbl));
                n = sel ? exp_wr_b.size() : exp_wr_a.size();
                chk("writes_pending_at_done", 64'(n), 64'd0);
            end
        end
    endtask

    initial begin : mon_a_blk
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) mon_step(1'b0, bus_a.mem_wr_en, bus_a.mem_addr, bus_a.mem_wr_data,
                                bus_a.done && !prev, bus_a.corr_cnt, bus_a.dbl_cnt);
            prev = bus_a.done;
        end
    end

    initial begin : mon_b_blk
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) mon_step(1'b1, bus_b.mem_wr_en, bus_b.mem_addr, bus_b.mem_wr_data,
                                bus_b.done && !prev, bus_b.corr_cnt, bus_b.dbl_cnt);
            prev = bus_b.done;
        end
    end

    // ---------------- test sequence ----------------
    initial begin : stim
        logic [63:0] d, c, r;
        int corr, dbl, nf, b1, b2, cyc;
        bus_a.start = 1'b0; bus_a.mode = 2'd0; bus_a.src_base = '0; bus_a.dst_base = '0; bus_a.count = '0;
        bus_b.start = 1'b0; bus_b.mode = 2'd0; bus_b.src_base = '0; bus_b.dst_base = '0; bus_b.count = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(bus_a.busy), 64'd0);
        chk("reset_done", 64'(bus_a.done), 64'd0);
        chk("reset_wr_en", 64'(bus_a.mem_wr_en), 64'd0);
        chk("reset_addr", 64'(bus_a.mem_addr), 64'd0);
        chk("reset_corr", 64'(bus_a.corr_cnt), 64'd0);
        chk("reset_dbl", 64'(bus_a.dbl_cnt), 64'd0);
        rst_n = 1'b1;

        // T1: encode, source wraps past address 0xFF.
        put_word(0, 8'hFE, 64'h000, 2);
        put_word(0, 8'h00, 64'h7FF, 2);
        put_word(0, 8'h02, 64'hF801, 2);   // bits above DATA_W must be ignored
        expect_word(0, 8'h40, 64'h0000, 2);
        expect_word(0, 8'h42, 64'hFFFF, 2);
        expect_word(0, 8'h44, 64'h000F, 2);
        expect_job(0, 0, 0);
        run_job(0, 2'd0, 8'hFE, 8'h40, 8'd3, 18);

        // T2: single errors at position 9 and at bit 0.
        put_word(0, 8'h20, 64'h020F, 2);
        put_word(0, 8'h22, 64'h000E, 2);
        expect_word(0, 8'h50, 64'h0001, 2);
        expect_word(0, 8'h52, 64'h0001, 2);
        expect_job(0, 2, 0);
        run_job(0, 2'd1, 8'h20, 8'h50, 8'd2, 12);

        // T3: double error, decoded in place.
        put_word(0, 8'h30, 64'h021F, 2);
        expect_word(0, 8'h30, 64'h8011, 2);
        expect_job(0, 0, 1);
        run_job(0, 2'd1, 8'h30, 8'h30, 8'd1, 6);

        // T4: random words with one or two flipped bits.
        corr = 0; dbl = 0;
        for (int w = 0; w < 15; w++) begin
            d  = 64'($urandom_range(0, 2047));
            c  = m_encode(16, d);
            nf = $urandom_range(1, 2);
            b1 = $urandom_range(0, 15);
            c[b1] = ~c[b1];
            if (nf == 2) begin
                b2 = (b1 + $urandom_range(1, 15)) % 16;
                c[b2] = ~c[b2];
            end
            put_word(0, 8'h80 + 8'(2*w), c, 2);
            if (nf == 1) begin
                expect_word(0, 8'hA0 + 8'(2*w), d, 2);
                corr++;
            end else begin
                r = m_decode(16, c);
                expect_word(0, 8'hA0 + 8'(2*w), r, 2);
                dbl++;
            end
        end
        expect_job(0, 8'(corr), 8'(dbl));
        run_job(0, 2'd1, 8'h80, 8'hA0, 8'd15, 90);
        expect_job(0, 8'(corr), 8'(dbl));
        run_job(0, 2'd2 + 2'($urandom_range(0, 1)), 8'h80, 8'h00, 8'd15, 60);

        // count=0 from DONE.
        expect_job(0, 0, 0);
        run_job(0, 2'd0, 8'h00, 8'h00, 8'd0, 1);

        // T5: DATA_W=26 instance.
        put_word(1, 8'h00, 64'h1, 4);
        expect_word(1, 8'h10, 64'h0000000F, 4);
        expect_job(1, 0, 0);
        run_job(1, 2'd0, 8'h00, 8'h10, 8'd1, 10);
        put_word(1, 8'h20, 64'h8000000F, 4);
        expect_word(1, 8'h30, 64'h00000001, 4);
        expect_job(1, 1, 0);
        run_job(1, 2'd1, 8'h20, 8'h30, 8'd1, 10);
        d = 64'($urandom_range(0, 32'h3FFFFFF));
        put_word(1, 8'h40, d, 4);
        expect_word(1, 8'h50, m_encode(32, d), 4);
        expect_job(1, 0, 0);
        run_job(1, 2'd0, 8'h40, 8'h50, 8'd1, 10);

        // T6: reset asserted during WRITE, then a clean rerun.
        mon_ignore = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.mode = 2'd0; bus_a.src_base = 8'hFE; bus_a.dst_base = 8'h60; bus_a.count = 8'd3;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 0;
        while (!bus_a.mem_wr_en && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6_reached_write", 64'(bus_a.mem_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en", 64'(bus_a.mem_wr_en), 64'd0);
        chk("t6_busy", 64'(bus_a.busy), 64'd0);
        chk("t6_done", 64'(bus_a.done), 64'd0);
        chk("t6_corr", 64'(bus_a.corr_cnt), 64'd0);
        chk("t6_dbl", 64'(bus_a.dbl_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_ignore = 1'b0;
        expect_word(0, 8'h60, 64'h0000, 2);
        expect_word(0, 8'h62, 64'hFFFF, 2);
        expect_word(0, 8'h64, 64'h000F, 2);
        expect_job(0, 0, 0);
        run_job(0, 2'd0, 8'hFE, 8'h60, 8'd3, 18);

        repeat (4) @(negedge clk);
        chk("leftover_writes_a", 64'(exp_wr_a.size()), 64'd0);
        chk("leftover_jobs_a", 64'(exp_job_a.size()), 64'd0);
        chk("leftover_writes_b", 64'(exp_wr_b.size()), 64'd0);
        chk("leftover_jobs_b", 64'(exp_job_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
